// File: rtl/flash_sequencer.sv
// Frame-rate flash sequencer: runs a programmable ON/OFF pattern counted in frame ticks,
// either as a finite burst or continuously, and drives flash enable / intensity.
module flash_sequencer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEPTH_W = 3,
  parameter int unsigned BURST_W = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic [CNT_W-1:0]   i_on_frames,
  input  logic [CNT_W-1:0]   i_off_frames,
  input  logic [BURST_W-1:0] i_burst_len,
  output logic               o_flash_on,
  output logic [DEPTH_W-1:0] o_rgb_depth,
  output logic [BURST_W-1:0] o_flash_cnt,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  localparam logic [CNT_W:0]   CntOne   = 1;
  localparam logic [BURST_W-1:0] BurstOne = 1;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_d;
  logic [CNT_W-1:0]   r_on_len, w_on_len_d;
  logic [CNT_W-1:0]   r_off_len, w_off_len_d;
  logic [BURST_W-1:0] r_burst_len, w_burst_len_d;
  logic [BURST_W-1:0] r_flash_cnt, w_flash_cnt_d;
  logic               r_flash_on, w_flash_on_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic [DEPTH_W-1:0] r_rgb_depth, w_rgb_depth_d;

  logic [CNT_W:0]     w_on_eff, w_off_eff, w_cnt_inc;
  logic [BURST_W-1:0] w_flash_inc;

  // A programmed phase length of zero behaves as a single frame.
  assign w_on_eff    = (r_on_len  == '0) ? CntOne : {1'b0, r_on_len};
  assign w_off_eff   = (r_off_len == '0) ? CntOne : {1'b0, r_off_len};
  assign w_cnt_inc   = {1'b0, r_frame_cnt} + CntOne;
  assign w_flash_inc = r_flash_cnt + BurstOne;

  always_comb begin
    w_state_d     = r_state;
    w_frame_cnt_d = r_frame_cnt;
    w_on_len_d    = r_on_len;
    w_off_len_d   = r_off_len;
    w_burst_len_d = r_burst_len;
    w_flash_cnt_d = r_flash_cnt;
    w_done_d      = 1'b0;

    if (!i_enable) begin
      w_state_d     = StIdle;
      w_frame_cnt_d = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_on_len_d    = i_on_frames;
            w_off_len_d   = i_off_frames;
            w_burst_len_d = i_burst_len;
            w_frame_cnt_d = '0;
            w_flash_cnt_d = '0;
            w_state_d     = StOn;
          end
        end
        StOn: begin
          if (i_frame_tick) begin
            if (w_cnt_inc == w_on_eff) begin
              w_frame_cnt_d = '0;
              w_state_d     = StOff;
            end else begin
              w_frame_cnt_d = w_cnt_inc[CNT_W-1:0];
            end
          end
        end
        StOff: begin
          if (i_frame_tick) begin
            if (w_cnt_inc == w_off_eff) begin
              w_frame_cnt_d = '0;
              w_flash_cnt_d = w_flash_inc;
              if (r_burst_len != '0 && w_flash_inc == r_burst_len) begin
                w_state_d = StIdle;
                w_done_d  = 1'b1;
              end else begin
                w_state_d = StOn;
              end
            end else begin
              w_frame_cnt_d = w_cnt_inc[CNT_W-1:0];
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    // Outputs are registered from the next state so they track the state register.
    w_flash_on_d  = (w_state_d == StOn);
    w_busy_d      = (w_state_d != StIdle);
    w_rgb_depth_d = (w_state_d == StOff) ? '0 : '1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_frame_cnt <= '0;
      r_on_len    <= '0;
      r_off_len   <= '0;
      r_burst_len <= '0;
      r_flash_cnt <= '0;
      r_flash_on  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rgb_depth <= '1;
    end else begin
      r_state     <= w_state_d;
      r_frame_cnt <= w_frame_cnt_d;
      r_on_len    <= w_on_len_d;
      r_off_len   <= w_off_len_d;
      r_burst_len <= w_burst_len_d;
      r_flash_cnt <= w_flash_cnt_d;
      r_flash_on  <= w_flash_on_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_rgb_depth <= w_rgb_depth_d;
    end
  end

  assign o_flash_on  = r_flash_on;
  assign o_rgb_depth = r_rgb_depth;
  assign o_flash_cnt = r_flash_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_flash_sequencer.sv
// Bench for flash_sequencer: directed scenarios plus random traffic, checked every cycle
// against a model that derives outputs from the tick count since start.
module tb_flash_sequencer;

  logic       clk = 1'b0;
  logic       i_reset, i_enable, i_frame_tick, i_start;
  logic [7:0] i_on_frames, i_off_frames;
  logic [3:0] i_burst_len;
  logic       o_flash_on, o_busy, o_done;
  logic [2:0] o_rgb_depth;
  logic [3:0] o_flash_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: position in the pattern is simply ticks-since-start modulo (on + off).
  bit m_active;
  int m_t, m_a, m_b, m_burst, m_cnt_idle;
  bit m_done;

  flash_sequencer dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_frame_tick (i_frame_tick),
    .i_start      (i_start),
    .i_on_frames  (i_on_frames),
    .i_off_frames (i_off_frames),
    .i_burst_len  (i_burst_len),
    .o_flash_on   (o_flash_on),
    .o_rgb_depth  (o_rgb_depth),
    .o_flash_cnt  (o_flash_cnt),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic model_update(bit tick, bit start, bit rst, bit en);
    int p;
    m_done = 1'b0;
    p = m_a + m_b;
    if (rst) begin
      m_active = 1'b0;
      m_cnt_idle = 0;
    end else if (!en) begin
      if (m_active) m_cnt_idle = (m_t / p) % 16;
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_t      = 0;
        m_a      = (i_on_frames == 0) ? 1 : int'(i_on_frames);
        m_b      = (i_off_frames == 0) ? 1 : int'(i_off_frames);
        m_burst  = int'(i_burst_len);
      end
    end else if (tick) begin
      m_t++;
      if (m_burst != 0 && m_t == m_burst * p) begin
        m_active   = 1'b0;
        m_done     = 1'b1;
        m_cnt_idle = m_burst;
      end
    end
  endtask

  task automatic check(string tag);
    int p, pos;
    logic       e_on, e_busy;
    logic [2:0] e_rgb;
    logic [3:0] e_cnt;
    if (m_active) begin
      p      = m_a + m_b;
      pos    = m_t % p;
      e_on   = (pos < m_a);
      e_busy = 1'b1;
      e_rgb  = e_on ? 3'd7 : 3'd0;
      e_cnt  = 4'((m_t / p) % 16);
    end else begin
      e_on   = 1'b0;
      e_busy = 1'b0;
      e_rgb  = 3'd7;
      e_cnt  = 4'(m_cnt_idle);
    end
    n_tests++;
    assert (o_flash_on === e_on) else begin
      n_fail++;
      $error("FAIL %s flash_on: got %0b expected %0b", tag, o_flash_on, e_on);
    end
    n_tests++;
    assert (o_rgb_depth === e_rgb) else begin
      n_fail++;
      $error("FAIL %s rgb_depth: got %0d expected %0d", tag, o_rgb_depth, e_rgb);
    end
    n_tests++;
    assert (o_busy === e_busy) else begin
      n_fail++;
      $error("FAIL %s busy: got %0b expected %0b", tag, o_busy, e_busy);
    end
    n_tests++;
    assert (o_flash_cnt === e_cnt) else begin
      n_fail++;
      $error("FAIL %s flash_cnt: got %0d expected %0d", tag, o_flash_cnt, e_cnt);
    end
    n_tests++;
    assert (o_done === m_done) else begin
      n_fail++;
      $error("FAIL %s done: got %0b expected %0b", tag, o_done, m_done);
    end
  endtask

  task automatic cycle(bit tick, bit start, bit rst, string tag);
    i_frame_tick = tick;
    i_start      = start;
    i_reset      = rst;
    model_update(tick, start, rst, i_enable);
    @(posedge clk);
    #1;
    i_frame_tick = 1'b0;
    i_start      = 1'b0;
    i_reset      = 1'b0;
    check(tag);
  endtask

  task automatic set_cfg(int on_f, int off_f, int burst);
    i_on_frames  = 8'(on_f);
    i_off_frames = 8'(off_f);
    i_burst_len  = 4'(burst);
  endtask

  // gap-1 quiet cycles followed by one tick cycle
  task automatic tick_after(int gap, string tag);
    for (int i = 0; i < gap - 1; i++) cycle(1'b0, 1'b0, 1'b0, tag);
    cycle(1'b1, 1'b0, 1'b0, tag);
  endtask

  initial begin
    i_reset = 1'b1; i_enable = 1'b1; i_frame_tick = 1'b0; i_start = 1'b0;
    set_cfg(0, 0, 0);
    m_active = 1'b0; m_t = 0; m_a = 1; m_b = 1; m_burst = 0; m_cnt_idle = 0; m_done = 1'b0;

    // Reset and idle
    cycle(1'b0, 1'b0, 1'b1, "reset");
    cycle(1'b0, 1'b0, 1'b1, "reset");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, "idle");

    // Finite burst 2/3 x2, tick every 10 cycles
    set_cfg(2, 3, 2);
    cycle(1'b0, 1'b1, 1'b0, "burst_start");
    for (int k = 0; k < 10; k++) tick_after(10, "burst");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, "burst_after");

    // Continuous 1/1, flash count wraps
    set_cfg(1, 1, 0);
    cycle(1'b0, 1'b1, 1'b0, "cont_start");
    for (int k = 0; k < 40; k++) tick_after(2, "cont");

    // Zero lengths act as one; stop by enable
    i_enable = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "cont_stop");
    i_enable = 1'b1;
    set_cfg(0, 0, 3);
    cycle(1'b1, 1'b1, 1'b0, "zero_start_tick");
    for (int k = 0; k < 6; k++) tick_after(3, "zero_len");
    cycle(1'b0, 1'b0, 1'b0, "zero_after");

    // Enable drop with tick mid-ON
    set_cfg(3, 2, 4);
    cycle(1'b0, 1'b1, 1'b0, "en_start");
    tick_after(4, "en_on");
    i_enable = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, "en_drop");
    i_enable = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, "en_idle");

    // Start while busy is ignored
    set_cfg(2, 2, 2);
    cycle(1'b0, 1'b1, 1'b0, "busy_start");
    tick_after(2, "busy_run");
    set_cfg(1, 1, 1);
    cycle(1'b0, 1'b1, 1'b0, "busy_restart");
    for (int k = 0; k < 8; k++) tick_after(2, "busy_run2");

    // Reset during OFF with flash count 1, then clean restart
    set_cfg(1, 1, 3);
    cycle(1'b0, 1'b1, 1'b0, "rst_start");
    for (int k = 0; k < 3; k++) tick_after(2, "rst_run");
    cycle(1'b0, 1'b0, 1'b1, "rst_off");
    cycle(1'b0, 1'b1, 1'b0, "rst_restart");
    for (int k = 0; k < 6; k++) tick_after(2, "rst_rerun");

    // Random traffic
    for (int run = 0; run < 12; run++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      cycle(1'b0, 1'b1, 1'b0, "rnd_start");
      for (int c = 0; c < 120; c++) begin
        bit tk, st;
        tk = ($urandom_range(0, 2) == 0);
        st = ($urandom_range(0, 9) == 0);
        if (st) set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
        i_enable = ($urandom_range(0, 39) != 0);
        cycle(tk, st, 1'b0, "rnd");
      end
      i_enable = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_sequencer.md
Name: flash_sequencer

Overview:
- Frame-rate controller that sequences the flash datapath of the VGA pipeline.
- Counts frames from the timing generator's frame tick and runs a programmable ON/OFF flash pattern, either as a finite burst or continuously.
- Drives the flash enable and the rgbDepth intensity level used by the pixel output stage.
- Reports progress through busy, done and flashCnt.

Parameters:
- CNT_W, 8, width of the per-phase frame counters and the onFrames/offFrames inputs.
- DEPTH_W, 3, width of rgbDepth; full intensity is all ones.
- BURST_W, 4, width of burstLen and flashCnt.

Ports:
- clock  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global flash enable; low forces IDLE.
- frameTick  in  1  single-cycle pulse at start of each frame (vsync).
- start  in  1  single-cycle request to begin a flash sequence.
- onFrames  in  CNT_W  frames per ON phase, sampled at start.
- offFrames  in  CNT_W  frames per OFF phase, sampled at start.
- burstLen  in  BURST_W  ON/OFF cycles to run; 0 = continuous.
- flashOn  out  1  high during ON phase.
- rgbDepth  out  DEPTH_W  intensity to pixel stage.
- flashCnt  out  BURST_W  completed ON/OFF cycles in current sequence.
- busy  out  1  high in ON or OFF.
- done  out  1  one-cycle pulse when a finite burst completes.

Behaviour:
- All outputs registered. Changes appear the cycle after the causing input edge.
- Reset: state=IDLE, flashOn=0, rgbDepth=all ones, flashCnt=0, busy=0, done=0, frame counter=0, shadow registers=0. Reset wins over every other input on the same cycle.
- State IDLE: rgbDepth=all ones, flashOn=0, busy=0.
  - start=1 and enable=1: latch onFrames, offFrames, burstLen into shadow registers; clear the frame counter and flashCnt; go to ON.
  - A latched value of 0 in onFrames or offFrames is treated as 1.
- State ON: flashOn=1, rgbDepth=all ones, busy=1.
  - Each frameTick increments the frame counter.
  - On the frameTick where counter+1 == latched onFrames: clear the counter and go to OFF.
  - Ticks before the phase is entered are not counted.
- State OFF: flashOn=0, rgbDepth=0, busy=1.
  - On the frameTick where counter+1 == latched offFrames: clear the counter and increment flashCnt (wraps modulo 2^BURST_W in continuous mode).
  - If latched burstLen != 0 and flashCnt+1 == burstLen: go to IDLE, pulse done for exactly one cycle, hold flashCnt at its final value until the next start.
  - Otherwise go to ON.
- enable=0 in any state: go to IDLE next cycle, clear the counter, no done pulse, flashCnt retains its value. Takes priority over frameTick and start on the same cycle.
- start while busy: ignored. Shadow registers are not updated; changes to onFrames/offFrames/burstLen mid-sequence have no effect.
- start and frameTick on the same cycle in IDLE: enter ON; that tick is not counted.
- Frame counter never exceeds latched phase length − 1; no overflow possible.

Test Plan:
1. reset=1 for 2 cycles, then idle → flashOn=0, rgbDepth=7, busy=0, flashCnt=0, done=0.
2. start with onFrames=2, offFrames=3, burstLen=2; frameTick every 10 cycles:
   - flashOn high for exactly 2 ticks, then low (rgbDepth=0) for 3 ticks.
   - Repeats once more; flashCnt goes 0→1→2.
   - done pulses 1 cycle after the 10th tick; busy drops the same cycle.
3. burstLen=0, onFrames=1, offFrames=1, run 40 ticks → flashOn toggles every tick, done never asserts, flashCnt wraps 15→0.
4. onFrames=0, offFrames=0 → behaves as 1/1 (ON one tick, OFF one tick).
5. Mid-ON, deassert enable together with a frameTick → next cycle IDLE, rgbDepth=7, busy=0, no done. A second start while busy (in a separate run) is ignored and counts are unchanged.
6. Assert reset during OFF with flashCnt=1 → next cycle all outputs at reset values. A subsequent start restarts cleanly from flashCnt=0.
